// File: rtl/mipi_csi_pkg.sv
// Shared types and constants for the CSI-2 lane byte aligner.
// Optional build macro: MIPI_BYTE_ALIGNER_SOT_ERR_TOL_EN (enables the single-bit-error sync helper's use).
package mipi_csi_pkg;

    localparam int LANE_W   = 8;
    localparam int OFFSET_W = 3;

    localparam logic [LANE_W-1:0] SYNC_BYTE_DEFAULT = 8'hB8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    // True when a and b differ in at most one bit position.
    function automatic logic within_one_bit(input logic [LANE_W-1:0] a,
                                            input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] diff;
        diff = a ^ b;
        return ((diff & (diff - LANE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/mipi_csi_byte_aligner_if.sv
// Lane-side bus of the byte aligner: raw bytes in, aligned bytes and status out.
interface mipi_csi_byte_aligner_if;
    import mipi_csi_pkg::*;

    logic [LANE_W-1:0]   byte_i;
    logic                byte_valid_i;
    logic [LANE_W-1:0]   byte_o;
    logic                byte_valid_o;
    logic                synced_o;
    logic [OFFSET_W-1:0] offset_o;
    logic                hunt_timeout_o;
    logic                sot_err_o;

    modport master (
        output byte_i, byte_valid_i,
        input  byte_o, byte_valid_o, synced_o, offset_o, hunt_timeout_o, sot_err_o
    );

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_o, byte_valid_o, synced_o, offset_o, hunt_timeout_o, sot_err_o
    );

endinterface

// File: rtl/mipi_sync_detector.sv
// Combinational SoT sync search over the 16-bit window at all eight bit offsets.
// MIPI_BYTE_ALIGNER_SOT_ERR_TOL_EN additionally accepts candidates one bit away from the sync byte.
module mipi_sync_detector
    import mipi_csi_pkg::*;
#(
    parameter logic [LANE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic [2*LANE_W-1:0] win,
    output logic                hit,
    output logic [OFFSET_W-1:0] offset,
    output logic                inexact
);

    logic [LANE_W-1:0] exact_vec;
    logic [LANE_W-1:0] near_vec;

    genvar gi;
    generate
        for (gi = 0; gi < LANE_W; gi++) begin : g_cand
            assign exact_vec[gi] = (win[gi+LANE_W-1:gi] == SYNC_BYTE);
`ifdef MIPI_BYTE_ALIGNER_SOT_ERR_TOL_EN
            assign near_vec[gi]  = within_one_bit(win[gi+LANE_W-1:gi], SYNC_BYTE);
`else
            assign near_vec[gi]  = 1'b0;
`endif
        end
    endgenerate

    // Any exact hit beats every near hit; descending scans leave the lowest offset in place.
    always_comb begin
        hit     = 1'b0;
        offset  = '0;
        inexact = 1'b0;
        if (|exact_vec) begin
            hit = 1'b1;
            for (int k = LANE_W - 1; k >= 0; k--) begin
                if (exact_vec[k]) offset = OFFSET_W'(k);
            end
        end else if (|near_vec) begin
            hit     = 1'b1;
            inexact = 1'b1;
            for (int k = LANE_W - 1; k >= 0; k--) begin
                if (near_vec[k]) offset = OFFSET_W'(k);
            end
        end
    end

endmodule

// File: rtl/mipi_csi_byte_aligner.sv
// D-PHY lane byte aligner: hunts for the SoT sync byte at any bit offset, then emits aligned payload.
// Build option MIPI_BYTE_ALIGNER_SOT_ERR_TOL_EN lets a one-bit-corrupted sync lock and flag sot_err_o.
module mipi_csi_byte_aligner
    import mipi_csi_pkg::*;
#(
    parameter logic [LANE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned       HUNT_TIMEOUT = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    aligner_reset_i,
    mipi_csi_byte_aligner_if.slave  lane
);

    localparam int CNT_W = $clog2(HUNT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HUNT_TIMEOUT - 1);

    align_state_t        state_reg,      state_next;
    logic [LANE_W-1:0]   prev_reg,       prev_next;
    logic [CNT_W-1:0]    count_reg,      count_next;
    logic [LANE_W-1:0]   byte_reg,       byte_next;
    logic                byte_valid_reg, byte_valid_next;
    logic [OFFSET_W-1:0] offset_reg,     offset_next;
    logic                timeout_reg,    timeout_next;
    logic                sot_err_reg,    sot_err_next;

    logic [2*LANE_W-1:0] win;
    logic                det_hit;
    logic [OFFSET_W-1:0] det_offset;
    logic                det_inexact;

    // Earlier bits sit in the low half, so bit 0 of the window is the oldest bit on the wire.
    assign win = {lane.byte_i, prev_reg};

    mipi_sync_detector #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_detector (
        .win     (win),
        .hit     (det_hit),
        .offset  (det_offset),
        .inexact (det_inexact)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg      <= HUNT;
            prev_reg       <= '0;
            count_reg      <= '0;
            byte_reg       <= '0;
            byte_valid_reg <= 1'b0;
            offset_reg     <= '0;
            timeout_reg    <= 1'b0;
            sot_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            count_reg      <= count_next;
            byte_reg       <= byte_next;
            byte_valid_reg <= byte_valid_next;
            offset_reg     <= offset_next;
            timeout_reg    <= timeout_next;
            sot_err_reg    <= sot_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        prev_next       = prev_reg;
        count_next      = count_reg;
        byte_next       = byte_reg;
        byte_valid_next = 1'b0;
        offset_next     = offset_reg;
        timeout_next    = 1'b0;
        sot_err_next    = 1'b0;

        if (aligner_reset_i) begin
            state_next  = HUNT;
            prev_next   = '0;
            count_next  = '0;
            byte_next   = '0;
            offset_next = '0;
        end else if (lane.byte_valid_i) begin
            prev_next = lane.byte_i;
            unique case (state_reg)
                HUNT: begin
                    if (det_hit) begin
                        state_next   = LOCKED;
                        offset_next  = det_offset;
                        count_next   = '0;
                        sot_err_next = det_inexact;
                    end else if (count_reg == CNT_LAST) begin
                        timeout_next = 1'b1;
                        count_next   = '0;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    byte_next       = win[offset_reg +: LANE_W];
                    byte_valid_next = 1'b1;
                end
            endcase
        end
    end

    assign lane.byte_o         = byte_reg;
    assign lane.byte_valid_o   = byte_valid_reg;
    assign lane.synced_o       = (state_reg == LOCKED);
    assign lane.offset_o       = offset_reg;
    assign lane.hunt_timeout_o = timeout_reg;
    assign lane.sot_err_o      = sot_err_reg;

endmodule

// File: tb/tb_mipi_csi_byte_aligner.sv
// Directed-vector bench for mipi_csi_byte_aligner; expectations adapt when MIPI_BYTE_ALIGNER_SOT_ERR_TOL_EN is defined.
module tb_mipi_csi_byte_aligner;
    import mipi_csi_pkg::*;

    localparam int TB_TIMEOUT = 16;
`ifdef MIPI_BYTE_ALIGNER_SOT_ERR_TOL_EN
    localparam bit TOL = 1'b1;
`else
    localparam bit TOL = 1'b0;
`endif

    logic clk           = 1'b0;
    logic reset_n       = 1'b0;
    logic aligner_reset = 1'b0;
    int   vectors       = 0;
    int   miscompares   = 0;

    mipi_csi_byte_aligner_if lane_bus ();

    mipi_csi_byte_aligner #(
        .SYNC_BYTE    (8'hB8),
        .HUNT_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .aligner_reset_i (aligner_reset),
        .lane            (lane_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one byte for one clock, then sit 1 time unit past the edge for sampling.
    task automatic step(input logic [7:0] b, input logic v);
        lane_bus.byte_i       = b;
        lane_bus.byte_valid_i = v;
        @(posedge clk);
        #1;
        $display("  in=%02h v=%0b -> out=%02h vo=%0b synced=%0b off=%0d to=%0b err=%0b",
                 b, v, lane_bus.byte_o, lane_bus.byte_valid_o, lane_bus.synced_o,
                 lane_bus.offset_o, lane_bus.hunt_timeout_o, lane_bus.sot_err_o);
    endtask

    task automatic rearm();
        aligner_reset         = 1'b1;
        lane_bus.byte_valid_i = 1'b0;
        @(posedge clk);
        #1;
        aligner_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        lane_bus.byte_i       = 8'h00;
        lane_bus.byte_valid_i = 1'b0;
        #1;
        outs = {lane_bus.byte_o, lane_bus.byte_valid_o, lane_bus.synced_o, lane_bus.offset_o,
                lane_bus.hunt_timeout_o, lane_bus.sot_err_o};
        vectors++;
        if (outs !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %04h want 0000", outs);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(8'h00, 1'b0);
        vectors++;
        if (lane_bus.synced_o !== 1'b0 || lane_bus.byte_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: synced=%0b vo=%0b want 0 0", lane_bus.synced_o, lane_bus.byte_valid_o);
        end
    endtask

    // Sync in {05,C0} at k=3; payload raw 92,A0,01 yields {92,05}>>3=40, {A0,92}>>3=12, {01,A0}>>3=34.
    task automatic test_offset3();
        logic [7:0] in_b  [5] = '{8'hC0, 8'h05, 8'h92, 8'hA0, 8'h01};
        logic       e_syn [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       e_vo  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] e_out [5] = '{8'h00, 8'h00, 8'h40, 8'h12, 8'h34};
        rearm();
        for (int i = 0; i < 5; i++) begin
            step(in_b[i], 1'b1);
            vectors++;
            if (lane_bus.synced_o !== e_syn[i] || lane_bus.byte_valid_o !== e_vo[i] ||
                (e_vo[i] && lane_bus.byte_o !== e_out[i])) begin
                miscompares++;
                $display("FAIL off3_step%0d: synced=%0b vo=%0b out=%02h want %0b %0b %02h",
                         i, lane_bus.synced_o, lane_bus.byte_valid_o, lane_bus.byte_o, e_syn[i], e_vo[i], e_out[i]);
            end
        end
        vectors++;
        if (lane_bus.offset_o !== 3'd3) begin
            miscompares++;
            $display("FAIL off3_offset: got %0d want 3", lane_bus.offset_o);
        end
    endtask

    // {AA,B8} matches at k=0; the next byte releases AA, B8 is never emitted.
    task automatic test_offset0();
        rearm();
        step(8'hB8, 1'b1);
        vectors++;
        if (lane_bus.synced_o !== 1'b0) begin
            miscompares++;
            $display("FAIL off0_early: synced=%0b want 0", lane_bus.synced_o);
        end
        step(8'hAA, 1'b1);
        vectors++;
        if (lane_bus.synced_o !== 1'b1 || lane_bus.offset_o !== 3'd0 || lane_bus.byte_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL off0_lock: synced=%0b off=%0d vo=%0b want 1 0 0",
                     lane_bus.synced_o, lane_bus.offset_o, lane_bus.byte_valid_o);
        end
        step(8'h55, 1'b1);
        vectors++;
        if (lane_bus.byte_valid_o !== 1'b1 || lane_bus.byte_o !== 8'hAA) begin
            miscompares++;
            $display("FAIL off0_first: vo=%0b out=%02h want 1 AA", lane_bus.byte_valid_o, lane_bus.byte_o);
        end
    endtask

    // Continues locked at k=0 with prev=55; a later B8 is just payload.
    task automatic test_gaps();
        logic [7:0] in_b  [6] = '{8'h3C, 8'hC3, 8'h00, 8'h77, 8'hB8, 8'h00};
        logic       in_v  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] e_out [6] = '{8'hAA, 8'h55, 8'h55, 8'hC3, 8'h77, 8'hB8};
        for (int i = 0; i < 6; i++) begin
            step(in_b[i], in_v[i]);
            vectors++;
            if (lane_bus.byte_valid_o !== in_v[i] || lane_bus.byte_o !== e_out[i] || lane_bus.synced_o !== 1'b1) begin
                miscompares++;
                $display("FAIL gaps_step%0d: vo=%0b out=%02h synced=%0b want %0b %02h 1",
                         i, lane_bus.byte_valid_o, lane_bus.byte_o, lane_bus.synced_o, in_v[i], e_out[i]);
            end
        end
    endtask

    task automatic test_timeout();
        rearm();
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            step(8'h00, 1'b1);
            vectors++;
            if (lane_bus.hunt_timeout_o !== (i == TB_TIMEOUT)) begin
                miscompares++;
                $display("FAIL timeout_a%0d: got %0b want %0b", i, lane_bus.hunt_timeout_o, (i == TB_TIMEOUT));
            end
        end
        step(8'h00, 1'b0);
        vectors++;
        if (lane_bus.hunt_timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse_width: got %0b want 0", lane_bus.hunt_timeout_o);
        end
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            step(8'h00, 1'b1);
            vectors++;
            if (lane_bus.hunt_timeout_o !== (i == TB_TIMEOUT) || lane_bus.synced_o !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_b%0d: to=%0b synced=%0b want %0b 0",
                         i, lane_bus.hunt_timeout_o, lane_bus.synced_o, (i == TB_TIMEOUT));
            end
        end
    endtask

    task automatic test_rearm();
        rearm();
        step(8'hC0, 1'b1);
        step(8'h05, 1'b1);
        step(8'h92, 1'b1);
        // Re-arm wins over a valid byte arriving on the same edge.
        aligner_reset         = 1'b1;
        lane_bus.byte_i       = 8'hA0;
        lane_bus.byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        aligner_reset = 1'b0;
        vectors++;
        if (lane_bus.synced_o !== 1'b0 || lane_bus.byte_valid_o !== 1'b0 ||
            lane_bus.byte_o !== 8'h00 || lane_bus.offset_o !== 3'd0) begin
            miscompares++;
            $display("FAIL rearm_clear: synced=%0b vo=%0b out=%02h off=%0d want 0 0 00 0",
                     lane_bus.synced_o, lane_bus.byte_valid_o, lane_bus.byte_o, lane_bus.offset_o);
        end
        step(8'hC0, 1'b1);
        step(8'h05, 1'b1);
        vectors++;
        if (lane_bus.synced_o !== 1'b1 || lane_bus.offset_o !== 3'd3) begin
            miscompares++;
            $display("FAIL rearm_relock: synced=%0b off=%0d want 1 3", lane_bus.synced_o, lane_bus.offset_o);
        end
        step(8'h92, 1'b1);
        vectors++;
        if (lane_bus.byte_valid_o !== 1'b1 || lane_bus.byte_o !== 8'h40) begin
            miscompares++;
            $display("FAIL rearm_payload: vo=%0b out=%02h want 1 40", lane_bus.byte_valid_o, lane_bus.byte_o);
        end
        // Asynchronous reset clears outputs without waiting for an edge.
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({lane_bus.byte_o, lane_bus.byte_valid_o, lane_bus.synced_o, lane_bus.offset_o,
             lane_bus.hunt_timeout_o, lane_bus.sot_err_o} !== 15'h0) begin
            miscompares++;
            $display("FAIL async_reset: out=%02h vo=%0b synced=%0b off=%0d want all 0",
                     lane_bus.byte_o, lane_bus.byte_valid_o, lane_bus.synced_o, lane_bus.offset_o);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(8'hC0, 1'b1);
        step(8'h05, 1'b1);
        vectors++;
        if (lane_bus.synced_o !== 1'b1 || lane_bus.offset_o !== 3'd3) begin
            miscompares++;
            $display("FAIL reset_relock: synced=%0b off=%0d want 1 3", lane_bus.synced_o, lane_bus.offset_o);
        end
    endtask

    // {00,B9}: B9 at k=0 is one bit from B8; stream 42,BB,00,00 keeps every candidate at least two bits away.
    task automatic test_tolerance();
        logic [7:0] bb_seq [4] = '{8'h42, 8'hBB, 8'h00, 8'h00};
        rearm();
        step(8'hB9, 1'b1);
        vectors++;
        if (lane_bus.synced_o !== 1'b0) begin
            miscompares++;
            $display("FAIL tol_early: synced=%0b want 0", lane_bus.synced_o);
        end
        step(8'h00, 1'b1);
        vectors++;
        if (lane_bus.synced_o !== TOL || lane_bus.sot_err_o !== TOL || (TOL && lane_bus.offset_o !== 3'd0)) begin
            miscompares++;
            $display("FAIL tol_b9_lock: synced=%0b err=%0b off=%0d want %0b %0b 0",
                     lane_bus.synced_o, lane_bus.sot_err_o, lane_bus.offset_o, TOL, TOL);
        end
        step(8'h00, 1'b1);
        vectors++;
        if (lane_bus.sot_err_o !== 1'b0 || lane_bus.synced_o !== TOL || lane_bus.byte_valid_o !== TOL) begin
            miscompares++;
            $display("FAIL tol_b9_after: err=%0b synced=%0b vo=%0b want 0 %0b %0b",
                     lane_bus.sot_err_o, lane_bus.synced_o, lane_bus.byte_valid_o, TOL, TOL);
        end
        rearm();
        for (int i = 0; i < 4; i++) begin
            step(bb_seq[i], 1'b1);
            vectors++;
            if (lane_bus.synced_o !== 1'b0 || lane_bus.sot_err_o !== 1'b0 || lane_bus.byte_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL tol_bb_step%0d: synced=%0b err=%0b vo=%0b want 0 0 0",
                         i, lane_bus.synced_o, lane_bus.sot_err_o, lane_bus.byte_valid_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_offset3();
        test_offset0();
        test_gaps();
        test_timeout();
        test_rearm();
        test_tolerance();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
